// File: rtl/traffic_pkg.sv
// Shared types and default dwell times for the traffic-light controller.
// Includes helpers for sizing counters at elaboration time.
package traffic_pkg;

  typedef enum logic [1:0] {
    ST_RED    = 2'b00,
    ST_GREEN  = 2'b01,
    ST_YELLOW = 2'b10
  } state_t;

  localparam int DEF_CLK_FREQ      = 100_000_000;
  localparam int DEF_RED_SEC       = 15;
  localparam int DEF_GREEN_SEC     = 20;
  localparam int DEF_MIN_GREEN_SEC = 5;
  localparam int DEF_YELLOW_SEC    = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Width of a counter that runs 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/traffic_cntl_sec_tick_gen.sv
// Prescaler counting 0..CLK_FREQ-1 with a one-cycle tick on the last count.
// A synchronous clear restarts the count so a new phase begins aligned.
module sec_tick_gen
  import traffic_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = cnt_width(CLK_FREQ);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_FREQ - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/traffic_cntl.sv
// Vehicle traffic-light controller: RED -> GREEN -> YELLOW with second-based
// dwell times, a pedestrian request that shortens green, and a 1 Hz heartbeat.
module traffic_cntl
  import traffic_pkg::*;
#(
  parameter int CLK_FREQ      = DEF_CLK_FREQ,
  parameter int RED_SEC       = DEF_RED_SEC,
  parameter int GREEN_SEC     = DEF_GREEN_SEC,
  parameter int MIN_GREEN_SEC = DEF_MIN_GREEN_SEC,
  parameter int YELLOW_SEC    = DEF_YELLOW_SEC
) (
  input  logic CLK,
  input  logic RST,
  input  logic PED_SW,
  output logic RED,
  output logic GREEN,
  output logic YELLOW,
  output logic WORK
);

  localparam int SEC_W = cnt_width(max3(RED_SEC, GREEN_SEC, YELLOW_SEC));
  localparam logic [SEC_W-1:0] RED_LAST    = SEC_W'(RED_SEC - 1);
  localparam logic [SEC_W-1:0] GREEN_LAST  = SEC_W'(GREEN_SEC - 1);
  localparam logic [SEC_W-1:0] YELLOW_LAST = SEC_W'(YELLOW_SEC - 1);
  localparam logic [SEC_W:0]   MIN_GREEN   = (SEC_W + 1)'(MIN_GREEN_SEC);

  state_t           r_state;
  state_t           w_state_next;
  logic [SEC_W-1:0] r_sec_cnt;
  logic             r_ped_meta;
  logic             r_ped_sync;
  logic             r_req;
  logic             r_work;
  logic             w_sec_tick;
  logic             w_hb_tick;
  logic             w_phase_clr;
  logic             w_serviced;
  logic             w_min_green_met;

  // Phase timer restarts on every transition; heartbeat never does.
  sec_tick_gen #(.CLK_FREQ(CLK_FREQ)) u_phase_tick (
    .CLK  (CLK),
    .RST  (RST),
    .clr  (w_phase_clr),
    .tick (w_sec_tick)
  );

  sec_tick_gen #(.CLK_FREQ(CLK_FREQ)) u_hb_tick (
    .CLK  (CLK),
    .RST  (RST),
    .clr  (1'b0),
    .tick (w_hb_tick)
  );

  assign w_phase_clr     = (w_state_next != r_state);
  assign w_serviced      = (r_state == ST_YELLOW) && (w_state_next == ST_RED);
  // Compare one bit wider so sec_cnt+1 cannot wrap.
  assign w_min_green_met = (({1'b0, r_sec_cnt} + (SEC_W + 1)'(1)) >= MIN_GREEN);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_RED;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RED: begin
        if (w_sec_tick && (r_sec_cnt == RED_LAST)) begin
          w_state_next = ST_GREEN;
        end
      end
      ST_GREEN: begin
        if (w_sec_tick && ((r_sec_cnt == GREEN_LAST) || (r_req && w_min_green_met))) begin
          w_state_next = ST_YELLOW;
        end
      end
      ST_YELLOW: begin
        if (w_sec_tick && (r_sec_cnt == YELLOW_LAST)) begin
          w_state_next = ST_RED;
        end
      end
      default: w_state_next = ST_RED;
    endcase
  end

  always_comb begin
    RED    = 1'b0;
    GREEN  = 1'b0;
    YELLOW = 1'b0;
    case (r_state)
      ST_GREEN:  GREEN  = 1'b1;
      ST_YELLOW: YELLOW = 1'b1;
      default:   RED    = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST || w_phase_clr) begin
      r_sec_cnt <= '0;
    end else if (w_sec_tick) begin
      r_sec_cnt <= r_sec_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ped_meta <= 1'b0;
      r_ped_sync <= 1'b0;
    end else begin
      r_ped_meta <= PED_SW;
      r_ped_sync <= r_ped_meta;
    end
  end

  // Servicing has priority: a press landing on the YELLOW->RED edge is dropped.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_req <= 1'b0;
    end else if (w_serviced) begin
      r_req <= 1'b0;
    end else if (r_ped_sync) begin
      r_req <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_work <= 1'b0;
    end else if (w_hb_tick) begin
      r_work <= ~r_work;
    end
  end

  assign WORK = r_work;

endmodule

// File: tb/tb_traffic_cntl.sv
// Scoreboard bench: stimulus pushes expected phase lengths, a negedge monitor
// measures each completed lamp phase and heartbeat half-period and compares.
module tb_traffic_cntl;

  localparam int HB = 100;
  localparam logic [2:0] L_RED    = 3'b100;
  localparam logic [2:0] L_GREEN  = 3'b010;
  localparam logic [2:0] L_YELLOW = 3'b001;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic PED_SW = 1'b0;
  logic RED, GREEN, YELLOW, WORK;

  typedef struct {
    logic [2:0] lamp;
    int         len;
  } phase_t;

  phase_t exp_q[$];
  int checks = 0;
  int errors = 0;

  traffic_cntl #(
    .CLK_FREQ      (100),
    .RED_SEC       (15),
    .GREEN_SEC     (20),
    .MIN_GREEN_SEC (5),
    .YELLOW_SEC    (3)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .PED_SW (PED_SW),
    .RED    (RED),
    .GREEN  (GREEN),
    .YELLOW (YELLOW),
    .WORK   (WORK)
  );

  always #5 CLK = ~CLK;

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  function automatic void push_phase(input logic [2:0] l, input int n);
    phase_t p;
    p.lamp = l;
    p.len  = n;
    exp_q.push_back(p);
  endfunction

  // Returns at the first negedge of a fresh phase showing lamp code.
  task automatic wait_enter(input logic [2:0] code, input string name);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (({RED, GREEN, YELLOW} == code) && (n < 6000));
    while (({RED, GREEN, YELLOW} != code) && (n < 6000)) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if ({RED, GREEN, YELLOW} != code) begin
      errors++;
      $display("FAIL wait_%s: lamps=%b after %0d cycles, required %b", name, {RED, GREEN, YELLOW}, n, code);
      finish_sim();
    end
  endtask

  task automatic press(input int delay, input int width);
    repeat (delay) @(posedge CLK);
    #1 PED_SW = 1'b1;
    repeat (width) @(posedge CLK);
    #1 PED_SW = 1'b0;
  endtask

  // Monitor: phase and heartbeat run lengths, one-hot lamps, reset values.
  initial begin
    logic [2:0] lamp, cur_lamp;
    logic       cur_work;
    int         run, wrun, phase_no;
    bit         started, fresh, rst_prev;
    phase_t     e;
    started = 0; fresh = 0; rst_prev = 0;
    run = 0; wrun = 0; phase_no = 0;
    cur_lamp = 3'b000; cur_work = 1'b0;
    forever begin
      @(negedge CLK);
      lamp = {RED, GREEN, YELLOW};
      if (RST) begin
        if (rst_prev) begin
          checks++;
          if (lamp != L_RED || WORK !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: lamps=%b work=%b, required lamps=100 work=0", lamp, WORK);
          end
        end
        rst_prev = 1; fresh = 1; started = 1;
      end else if (started) begin
        rst_prev = 0;
        checks++;
        if (!$onehot(lamp)) begin
          errors++;
          $display("FAIL onehot: lamps=%b, required exactly one lamp on", lamp);
        end
        if (fresh) begin
          checks++;
          if (lamp != L_RED || WORK !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: lamps=%b work=%b, required lamps=100 work=0", lamp, WORK);
          end
          cur_lamp = lamp; run = 1;
          cur_work = WORK; wrun = 1;
          fresh = 0;
        end else begin
          if (lamp == cur_lamp) begin
            run++;
          end else begin
            phase_no++;
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL phase_%0d: lamps=%b lasted %0d cycles, required no further phase", phase_no, cur_lamp, run);
            end else begin
              e = exp_q.pop_front();
              if (e.lamp != cur_lamp || e.len != run) begin
                errors++;
                $display("FAIL phase_%0d: lamps=%b lasted %0d cycles, required lamps=%b for %0d cycles", phase_no, cur_lamp, run, e.lamp, e.len);
              end else begin
                $display("phase %0d: lamps=%b cycles=%0d ok", phase_no, cur_lamp, run);
              end
            end
            cur_lamp = lamp; run = 1;
          end
          if (WORK == cur_work) begin
            wrun++;
          end else begin
            checks++;
            if (wrun != HB) begin
              errors++;
              $display("FAIL work_period: WORK=%b held %0d cycles, required %0d", cur_work, wrun, HB);
            end
            cur_work = WORK; wrun = 1;
          end
        end
      end
    end
  end

  initial begin
    #(60000 * 10);
    errors++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    finish_sim();
  end

  initial begin
    // Test 1 and 4: reset, then a plain cycle; heartbeat checked throughout.
    push_phase(L_RED, 1500);
    push_phase(L_GREEN, 2000);
    push_phase(L_YELLOW, 300);
    repeat (20) @(posedge CLK);
    #1 RST = 1'b0;
    wait_enter(L_GREEN, "green1");
    wait_enter(L_YELLOW, "yellow1");

    // Test 2: press during RED shortens the next green only.
    wait_enter(L_RED, "red2");
    push_phase(L_RED, 1500);
    push_phase(L_GREEN, 500);
    push_phase(L_YELLOW, 300);
    push_phase(L_RED, 1500);
    push_phase(L_GREEN, 2000);
    push_phase(L_YELLOW, 300);
    press(12, 3);
    wait_enter(L_RED, "red3");
    wait_enter(L_RED, "red4");

    // Test 3: late press in green ends it at the next second boundary.
    push_phase(L_RED, 1500);
    push_phase(L_GREEN, 1000);
    push_phase(L_YELLOW, 300);
    wait_enter(L_GREEN, "green4");
    press(900, 1);

    // Test 5: request pending into yellow, then reset mid-yellow.
    wait_enter(L_RED, "red5");
    push_phase(L_RED, 1500);
    push_phase(L_GREEN, 500);
    wait_enter(L_GREEN, "green5");
    press(100, 1);
    wait_enter(L_YELLOW, "yellow5");
    push_phase(L_RED, 1500);
    push_phase(L_GREEN, 2000);
    push_phase(L_YELLOW, 300);
    repeat (150) @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    wait_enter(L_GREEN, "green6");

    // Test 6: button held: every green is minimum length.
    wait_enter(L_RED, "red7");
    push_phase(L_RED, 1500);
    push_phase(L_GREEN, 500);
    push_phase(L_YELLOW, 300);
    push_phase(L_RED, 1500);
    push_phase(L_GREEN, 500);
    push_phase(L_YELLOW, 300);
    #1 PED_SW = 1'b1;
    wait_enter(L_RED, "red8");
    wait_enter(L_RED, "red9");
    PED_SW = 1'b0;
    repeat (5) @(negedge CLK);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d phases outstanding, required 0", exp_q.size());
    end
    finish_sim();
  end

endmodule
